// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter: loads a word via valid/ready and shifts it out MSB first.
// Define TX_PARITY_EN to append an even-parity bit after the data LSB.
module piso_shift_tx #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned CNT_W = 3
) (
  input  logic             ClkIn,
  input  logic             ClrIn,
  input  logic [WIDTH-1:0] DIn_p,
  input  logic             LdValid,
  output logic             LdReady,
  input  logic             ShiftEna,
  output logic             QOut,
  output logic             TxValid,
  output logic             Done
);

`ifdef TX_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NBITS - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sh_reg_q, sh_reg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               done_q, done_d;
  logic               last;
  logic               load;
`ifdef TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  assign last    = (state_q == StShift) && (bit_cnt_q == LastCnt);
  assign LdReady = (state_q == StIdle) || (last && ShiftEna);
  assign load    = LdValid && LdReady;

  always_comb begin
    state_d   = state_q;
    sh_reg_d  = sh_reg_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
`ifdef TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d   = StShift;
          sh_reg_d  = DIn_p;
          bit_cnt_d = '0;
`ifdef TX_PARITY_EN
          parity_d  = ^DIn_p;
`endif
        end
      end
      StShift: begin
        if (ShiftEna) begin
          if (last) begin
            done_d = 1'b1;
            // Reload on the last-bit edge keeps back-to-back frames gapless.
            if (LdValid) begin
              sh_reg_d  = DIn_p;
              bit_cnt_d = '0;
`ifdef TX_PARITY_EN
              parity_d  = ^DIn_p;
`endif
            end else begin
              state_d   = StIdle;
              sh_reg_d  = '0;
              bit_cnt_d = '0;
            end
          end else begin
            sh_reg_d  = {sh_reg_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ClkIn or posedge ClrIn) begin
    if (ClrIn) begin
      state_q   <= StIdle;
      sh_reg_q  <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sh_reg_q  <= sh_reg_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
`ifdef TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign TxValid = (state_q == StShift);
  assign Done    = done_q;

  always_comb begin
    QOut = 1'b0;
    if (TxValid) begin
`ifdef TX_PARITY_EN
      // The data register has shifted empty by the time the parity slot comes up.
      QOut = (bit_cnt_q == CNT_W'(WIDTH)) ? parity_q : sh_reg_q[WIDTH-1];
`else
      QOut = sh_reg_q[WIDTH-1];
`endif
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Scoreboard bench for piso_shift_tx: frame bits are queued on acceptance and checked per cycle.
module tb_piso_shift_tx;
  localparam int unsigned WIDTH = 5;
  localparam int unsigned CNT_W = 3;
`ifdef TX_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             clr = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic             ld_valid = 1'b0;
  logic             shift_ena = 1'b0;
  logic             ld_ready, qout, tx_valid, done;

  piso_shift_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .ClkIn   (clk),
    .ClrIn   (clr),
    .DIn_p   (din),
    .LdValid (ld_valid),
    .LdReady (ld_ready),
    .ShiftEna(shift_ena),
    .QOut    (qout),
    .TxValid (tx_valid),
    .Done    (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             b;
    logic             last;
    logic [WIDTH-1:0] word;
  } bit_t;

  bit_t             exp_q[$];
  logic             exp_done = 1'b0;
  logic [WIDTH-1:0] exp_rx = '0;
  int               acc_cnt = 0;
  int               checks = 0;
  int               errors = 0;
  int               mode = 0;
  int               pat_idx = 0;
  logic [NBITS-1:0] rx_sh = '0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is the word's bits MSB first (plus parity), one per enabled edge.
  always @(posedge clk) begin
    logic ready;
    logic cons_last;
    bit_t e;
    if (clr) begin
      exp_q.delete();
      exp_done = 1'b0;
    end else begin
      ready = (exp_q.size() == 0) || (exp_q[0].last && shift_ena);
      cons_last = 1'b0;
      if (exp_q.size() != 0 && shift_ena) begin
        cons_last = exp_q[0].last;
        if (cons_last) exp_rx = exp_q[0].word;
        void'(exp_q.pop_front());
      end
      exp_done = cons_last;
      if (ld_valid && ready) begin
        for (int i = WIDTH - 1; i >= 0; i--) begin
          e.b    = din[i];
          e.last = (NBITS == WIDTH) && (i == 0);
          e.word = din;
          exp_q.push_back(e);
        end
`ifdef TX_PARITY_EN
        e.b    = ^din;
        e.last = 1'b1;
        e.word = din;
        exp_q.push_back(e);
`endif
        acc_cnt++;
      end
    end
  end

  // Loop-back receiver sharing the shift enable.
  always @(posedge clk) begin
    if (shift_ena) rx_sh <= {rx_sh[NBITS-2:0], qout};
  end

  always @(negedge clk) begin
    logic exp_ready;
    logic [WIDTH-1:0] rx_word;
    exp_ready = (exp_q.size() == 0) || (exp_q[0].last && shift_ena);
    check1("tx_valid", tx_valid, exp_q.size() != 0);
    check1("qout", qout, (exp_q.size() != 0) ? exp_q[0].b : 1'b0);
    check1("done", done, exp_done);
    check1("ld_ready", ld_ready, exp_ready);
    if (exp_done) begin
      rx_word = rx_sh[NBITS-1 -: WIDTH];
      checks++;
      if (rx_word !== exp_rx) begin
        errors++;
        $display("FAIL rx_word: got %h expected %h at %0t", rx_word, exp_rx, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (mode)
      0: shift_ena = 1'b1;
      1: begin
        shift_ena = (pat_idx % 3 == 0);
        pat_idx++;
      end
      default: shift_ena = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic load(input logic [WIDTH-1:0] w);
    int start;
    start = acc_cnt;
    ld_valid = 1'b1;
    din = w;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (acc_cnt != start) begin
        ld_valid = 1'b0;
        din = ~w;
        return;
      end
    end
    errors++;
    $display("FAIL load_timeout: word %h never accepted at %0t", w, $time);
    ld_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      if (exp_q.size() == 0 && !exp_done) return;
      tick();
    end
    errors++;
    $display("FAIL idle_timeout: %0d bits still pending at %0t", exp_q.size(), $time);
  endtask

  initial begin
    tick();
    tick();
    clr = 1'b0;
    tick();

    mode = 0;
    load(5'h1c);
    wait_idle();

    mode = 1;
    pat_idx = 0;
    load(5'h15);
    wait_idle();

    mode = 0;
    load(5'h1c);
    load(5'h03);
    wait_idle();

    load(5'h1f);
    tick();
    tick();
    clr = 1'b1;
    exp_q.delete();
    exp_done = 1'b0;
    #1;
    check1("reset_qout", qout, 1'b0);
    check1("reset_tx_valid", tx_valid, 1'b0);
    check1("reset_done", done, 1'b0);
    tick();
    clr = 1'b0;
    tick();
    load(5'h01);
    wait_idle();

    load(5'h0f);
    tick();
    load(5'h12);
    wait_idle();

    load(5'h18);
    wait_idle();

    mode = 2;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      load(WIDTH'($urandom));
    end
    wait_idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
